// File: rtl/pulse_scan_ctrl.sv
// pulse_scan_ctrl: steps the pulse-generator delay across a list of scan points.
// Each point is held for n_shots counted periods. Outputs to the pulse generator
// change only on period_tick, so no period runs with a half-applied setting.
//
// Optional build macro: SCAN_SETTLE_EN -- discard the first period after every
// output load, so each point takes n_shots+1 periods.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   start, abort        one-cycle scan start / stop requests
//   period_tick         one-cycle strobe at each pulse-counter wrap
//   del_start, p2_start point-0 delay and pulse-2 stop values
//   del_step            per-point increment applied to both outputs
//   n_points, n_shots   scan length and counted shots per point
//   del_out, p2stop_out values driven to the pulse generator
//   point_idx           index of the current point
//   shot_valid          one-cycle strobe per counted shot
//   busy, done          scan active / one-cycle completion strobe
//   ovf                 sticky: scan stopped early because a step overflowed
module pulse_scan_ctrl #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic         period_tick,
  input  logic [W-1:0] del_start,
  input  logic [W-1:0] p2_start,
  input  logic [W-1:0] del_step,
  input  logic [W-1:0] n_points,
  input  logic [W-1:0] n_shots,
  output logic [W-1:0] del_out,
  output logic [W-1:0] p2stop_out,
  output logic [W-1:0] point_idx,
  output logic         shot_valid,
  output logic         busy,
  output logic         done,
  output logic         ovf
);

`ifdef SCAN_SETTLE_EN
  localparam logic SettleEn = 1'b1;
`else
  localparam logic SettleEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StArm, StRun, StDone} state_e;

  state_e state_q, state_d;

  // Latched scan configuration
  logic [W-1:0] del_start_q, p2_start_q, del_step_q, n_points_q, n_shots_q;
  logic         latch_cfg;

  logic [W-1:0] del_q, del_d;
  logic [W-1:0] p2_q, p2_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] shot_cnt_q, shot_cnt_d;
  logic         shot_valid_q, shot_valid_d;
  logic         ovf_q, ovf_d;
  logic         settle_q, settle_d;

  // Next-point values, one bit wider to catch the carry. They track the current
  // outputs one cycle behind, so a step at a tick is a plain register load.
  logic [W:0]   nxt_del_q, nxt_p2_q;

  logic [W-1:0] shot_inc, idx_inc;
  logic         step_carry;

  assign shot_inc   = shot_cnt_q + W'(1);
  assign idx_inc    = idx_q + W'(1);
  assign step_carry = nxt_del_q[W] | nxt_p2_q[W];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      del_q        <= '0;
      p2_q         <= '0;
      idx_q        <= '0;
      shot_cnt_q   <= '0;
      shot_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      settle_q     <= 1'b0;
      nxt_del_q    <= '0;
      nxt_p2_q     <= '0;
      del_start_q  <= '0;
      p2_start_q   <= '0;
      del_step_q   <= '0;
      n_points_q   <= '0;
      n_shots_q    <= '0;
    end else begin
      state_q      <= state_d;
      del_q        <= del_d;
      p2_q         <= p2_d;
      idx_q        <= idx_d;
      shot_cnt_q   <= shot_cnt_d;
      shot_valid_q <= shot_valid_d;
      ovf_q        <= ovf_d;
      settle_q     <= settle_d;
      nxt_del_q    <= {1'b0, del_q} + {1'b0, del_step_q};
      nxt_p2_q     <= {1'b0, p2_q} + {1'b0, del_step_q};
      if (latch_cfg) begin
        del_start_q <= del_start;
        p2_start_q  <= p2_start;
        del_step_q  <= del_step;
        n_points_q  <= n_points;
        n_shots_q   <= n_shots;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    del_d        = del_q;
    p2_d         = p2_q;
    idx_d        = idx_q;
    shot_cnt_d   = shot_cnt_q;
    shot_valid_d = 1'b0;
    ovf_d        = ovf_q;
    settle_d     = settle_q;
    latch_cfg    = 1'b0;

    if (abort) begin
      // Abort beats start and period_tick; outputs hold.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            latch_cfg = 1'b1;
            ovf_d     = 1'b0;
            state_d   = StArm;
          end
        end
        StArm: begin
          if (n_points_q == '0 || n_shots_q == '0) begin
            state_d = StDone;
          end else if (period_tick) begin
            del_d      = del_start_q;
            p2_d       = p2_start_q;
            idx_d      = '0;
            shot_cnt_d = '0;
            settle_d   = SettleEn;
            state_d    = StRun;
          end
        end
        StRun: begin
          if (period_tick) begin
            if (settle_q) begin
              settle_d = 1'b0;
            end else begin
              shot_valid_d = 1'b1;
              shot_cnt_d   = shot_inc;
              if (shot_inc == n_shots_q) begin
                if (idx_inc == n_points_q) begin
                  state_d = StDone;
                end else if (step_carry) begin
                  ovf_d   = 1'b1;
                  state_d = StDone;
                end else begin
                  del_d      = nxt_del_q[W-1:0];
                  p2_d       = nxt_p2_q[W-1:0];
                  idx_d      = idx_inc;
                  shot_cnt_d = '0;
                  settle_d   = SettleEn;
                end
              end
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign del_out    = del_q;
  assign p2stop_out = p2_q;
  assign point_idx  = idx_q;
  assign shot_valid = shot_valid_q;
  assign ovf        = ovf_q;
  assign busy       = (state_q == StArm) || (state_q == StRun);
  assign done       = (state_q == StDone);

endmodule
